// File: rtl/jk_pkg.sv
// jk_pkg: JK operation encoding and the per-bit next-state rule shared by the bank.
package jk_pkg;
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_op_e;

    function automatic logic jk_next(input jk_op_e op, input logic q);
        return (op == JK_TOG) ? ~q : (op == JK_SET) ? 1'b1 : (op == JK_CLR) ? 1'b0 : q;
    endfunction
endpackage

// File: rtl/jk_popcount.sv
// jk_popcount: combinational count of set bits in a WIDTH-bit vector.
module jk_popcount
    import jk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]           i_vec,
    output logic [$clog2(WIDTH+1)-1:0] o_cnt
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < WIDTH; i++) o_cnt = o_cnt + CNT_W'(i_vec[i]);
    end
endmodule

// File: rtl/jk_flop_bank.sv
// jk_flop_bank: WIDTH JK flip-flops with clear/load/enable priority, edge flags,
// a registered popcount of q and a saturating count of cycles where q changed.
module jk_flop_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CHG_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       sclr,
    input  logic                       load,
    input  logic [WIDTH-1:0]           d,
    input  logic [WIDTH-1:0]           j,
    input  logic [WIDTH-1:0]           k,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           rise,
    output logic [WIDTH-1:0]           fall,
    output logic [$clog2(WIDTH+1)-1:0] ones,
    output logic [CHG_W-1:0]           chg_cnt
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_q, r_rise, r_fall, w_jk, w_q_nxt;
    logic [CNT_W-1:0] r_ones, w_ones, w_rst_ones;
    logic [CHG_W-1:0] r_chg;
    logic             w_chg, w_sat;

    always_comb begin
        w_jk = r_q;
        for (int i = 0; i < WIDTH; i++) w_jk[i] = jk_next(jk_op_e'({j[i], k[i]}), r_q[i]);
    end

    // Ternary chain keeps d/j/k out of q_nxt unless their enable is active.
    assign w_q_nxt = sclr ? '0 : load ? d : en ? w_jk : r_q;
    assign w_chg   = w_q_nxt != r_q;
    assign w_sat   = &r_chg;

    jk_popcount #(.WIDTH(WIDTH)) u_pop     (.i_vec(r_q),       .o_cnt(w_ones));
    jk_popcount #(.WIDTH(WIDTH)) u_pop_rst (.i_vec(RESET_VAL), .o_cnt(w_rst_ones));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= RESET_VAL;
            r_rise <= '0;
            r_fall <= '0;
            r_ones <= w_rst_ones;
            r_chg  <= '0;
        end else begin
            r_q    <= w_q_nxt;
            r_rise <= w_q_nxt & ~r_q;
            r_fall <= ~w_q_nxt & r_q;
            r_ones <= w_ones;
            r_chg  <= sclr ? '0 : (w_chg && !w_sat) ? r_chg + CHG_W'(1) : r_chg;
        end
    end

    assign q       = r_q;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign ones    = r_ones;
    assign chg_cnt = r_chg;
endmodule
